// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Round-robin arbiter sharing the single PL-side AXI BRAM port between two
// requester engines. The winning access is registered onto the BRAM port and
// read data is routed back with a per-requester valid strobe two edges after
// acceptance (one edge for the port register, one for the BRAM itself).
// Optional feature: define BRAM_ARB_LOCK_EN to add reqN_lock ports that let a
// requester keep the port across accesses (atomic read-modify-write).

module bram_port_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wrdata,
  input  logic [DATA_W/8-1:0] req0_we,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wrdata,
  input  logic [DATA_W/8-1:0] req1_we,
`ifdef BRAM_ARB_LOCK_EN
  input  logic                req0_lock,
  input  logic                req1_lock,
`endif
  output logic                req0_ready,
  output logic                req1_ready,
  output logic                req0_rvalid,
  output logic                req1_rvalid,
  output logic [DATA_W-1:0]   rddata,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_wrdata,
  output logic [DATA_W/8-1:0] bram_we,
  input  logic [DATA_W-1:0]   bram_rddata
);

  localparam int WE_W = DATA_W / 8;

  // last_grant_q resets to 1 so requester 0 wins the first conflict
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic [WE_W-1:0]   we_q, we_d;
  // read-return pipeline: stage 1 aligns with the BRAM port register,
  // stage 2 aligns with bram_rddata
  logic              s1_read_q, s1_read_d;
  logic              s1_id_q, s1_id_d;
  logic              s2_read_q, s2_read_d;
  logic              s2_id_q, s2_id_d;

  logic              elig0, elig1;
  logic              grant0, grant1;

`ifdef BRAM_ARB_LOCK_EN
  logic              lock_active_q, lock_active_d;
  logic              lock_id_q, lock_id_d;

  // a held lock masks the non-owner out of arbitration
  always_comb begin
    elig0 = req0_valid && !(lock_active_q && lock_id_q);
    elig1 = req1_valid && !(lock_active_q && !lock_id_q);
  end
`else
  // without locking every valid requester is eligible
  always_comb begin
    elig0 = req0_valid;
    elig1 = req1_valid;
  end
`endif

  // round-robin grant; grants are suppressed while reset is asserted
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (elig0 && elig1) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  // next-state for the BRAM port register, grant history and return pipeline
  always_comb begin
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wrdata_d     = wrdata_q;
    we_d         = '0;
    s1_read_d    = 1'b0;
    s1_id_d      = 1'b0;
    s2_read_d    = s1_read_q;
    s2_id_d      = s1_id_q;
    if (grant0) begin
      addr_d       = req0_addr;
      wrdata_d     = req0_wrdata;
      we_d         = req0_we;
      last_grant_d = 1'b0;
      s1_read_d    = (req0_we == '0);
      s1_id_d      = 1'b0;
    end else if (grant1) begin
      addr_d       = req1_addr;
      wrdata_d     = req1_wrdata;
      we_d         = req1_we;
      last_grant_d = 1'b1;
      s1_read_d    = (req1_we == '0);
      s1_id_d      = 1'b1;
    end
  end

`ifdef BRAM_ARB_LOCK_EN
  // an accepted access rewrites the lock: lock=1 claims it, lock=0 from the
  // owner releases it (a non-owner can never be accepted while it is held)
  always_comb begin
    lock_active_d = lock_active_q;
    lock_id_d     = lock_id_q;
    if (grant0) begin
      lock_active_d = req0_lock;
      lock_id_d     = 1'b0;
    end else if (grant1) begin
      lock_active_d = req1_lock;
      lock_id_d     = 1'b1;
    end
  end

  // lock state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_active_q <= 1'b0;
      lock_id_q     <= 1'b0;
    end else begin
      lock_active_q <= lock_active_d;
      lock_id_q     <= lock_id_d;
    end
  end
`endif

  // state register; reset drops in-flight reads and any write still on the port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wrdata_q     <= '0;
      we_q         <= '0;
      s1_read_q    <= 1'b0;
      s1_id_q      <= 1'b0;
      s2_read_q    <= 1'b0;
      s2_id_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wrdata_q     <= wrdata_d;
      we_q         <= we_d;
      s1_read_q    <= s1_read_d;
      s1_id_q      <= s1_id_d;
      s2_read_q    <= s2_read_d;
      s2_id_q      <= s2_id_d;
    end
  end

  // output wiring
  always_comb begin
    req0_ready  = grant0;
    req1_ready  = grant1;
    req0_rvalid = s2_read_q && !s2_id_q;
    req1_rvalid = s2_read_q && s2_id_q;
    rddata      = bram_rddata;
    bram_addr   = addr_q;
    bram_wrdata = wrdata_q;
    bram_we     = we_q;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.

module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [12:0] req0_addr, req1_addr;
  logic [31:0] req0_wrdata, req1_wrdata;
  logic [3:0]  req0_we, req1_we;
`ifdef BRAM_ARB_LOCK_EN
  logic        req0_lock, req1_lock;
`endif
  logic        req0_ready, req1_ready, req0_rvalid, req1_rvalid;
  logic [31:0] rddata;
  logic [12:0] bram_addr;
  logic [31:0] bram_wrdata;
  logic [3:0]  bram_we;
  logic [31:0] bram_rddata;

  int n_checks = 0;
  int n_fail   = 0;

  bram_port_arbiter #(.ADDR_W(13), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wrdata(req0_wrdata), .req0_we(req0_we),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wrdata(req1_wrdata), .req1_we(req1_we),
`ifdef BRAM_ARB_LOCK_EN
    .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_rvalid(req0_rvalid), .req1_rvalid(req1_rvalid),
    .rddata(rddata), .bram_addr(bram_addr), .bram_wrdata(bram_wrdata),
    .bram_we(bram_we), .bram_rddata(bram_rddata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 2047) ? 32'hFFFF_FFFF : (32'hC0DE_0000 + 32'(i));
  endfunction

  // BRAM behaviour: registered read, byte-enabled write
  logic [31:0] mem [0:2047];
  initial for (int i = 0; i < 2048; i++) mem[i] = init_val(i);
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bram_we[i]) mem[bram_addr[12:2]][i*8 +: 8] <= bram_wrdata[i*8 +: 8];
    bram_rddata <= mem[bram_addr[12:2]];
  end

  // reference model: memory contents in accept order, grant history, lock,
  // and a list of reads due back at a given cycle number
  typedef struct { int due; bit id; logic [31:0] data; } ret_t;
  typedef struct { logic r0, r1; logic [3:0] we; logic [12:0] addr;
                   logic rv0, rv1; logic [31:0] rd; } obs_t;

  logic [31:0] ref_mem [0:2048-1];
  initial for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
  bit          m_last;
  bit          m_lk;
  bit          m_lkid;
  logic [12:0] m_addr;
  int          cyc = 0;
  ret_t        rq[$];

  task automatic model_reset();
    m_last = 1'b1;
    m_lk   = 1'b0;
    m_lkid = 1'b0;
    m_addr = '0;
    rq.delete();
  endtask

  // drive one cycle of requests, return what the DUT showed and what the model predicts
  task automatic cycle(input logic v0, input logic v1,
                       input logic [12:0] a0, input logic [12:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] w0, input logic [3:0] w1,
                       input logic l0, input logic l1,
                       output obs_t o, output obs_t e);
    bit el0, el1, g0, g1, id;
    logic [12:0] a;
    logic [31:0] d;
    logic [3:0]  w;
    ret_t r;
    req0_valid = v0; req0_addr = a0; req0_wrdata = d0; req0_we = w0;
    req1_valid = v1; req1_addr = a1; req1_wrdata = d1; req1_we = w1;
`ifdef BRAM_ARB_LOCK_EN
    req0_lock = l0; req1_lock = l1;
`endif
    #1;
    o.r0 = req0_ready;
    o.r1 = req1_ready;
    el0 = v0 && !(m_lk && m_lkid);
    el1 = v1 && !(m_lk && !m_lkid);
    if (el0 && el1) begin g0 = m_last; g1 = !m_last; end
    else begin g0 = el0; g1 = el1; end
    e.r0 = g0;
    e.r1 = g1;
    @(posedge clk);
    #1;
    cyc++;
    e.we = '0;
    if (g0 || g1) begin
      id = g1;
      a  = g1 ? a1 : a0;
      d  = g1 ? d1 : d0;
      w  = g1 ? w1 : w0;
      m_addr = a;
      m_last = id;
      m_lk   = g1 ? l1 : l0;
      m_lkid = id;
      e.we   = w;
      for (int i = 0; i < 4; i++) if (w[i]) ref_mem[a[12:2]][i*8 +: 8] = d[i*8 +: 8];
      if (w == 4'h0) rq.push_back('{due: cyc + 1, id: id, data: ref_mem[a[12:2]]});
    end
    e.addr = m_addr;
    e.rv0 = 1'b0; e.rv1 = 1'b0; e.rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.id) e.rv1 = 1'b1; else e.rv0 = 1'b1;
      e.rd = r.data;
    end
    o.we = bram_we; o.addr = bram_addr; o.rv0 = req0_rvalid; o.rv1 = req1_rvalid; o.rd = rddata;
  endtask

  task automatic idle(input int n);
    obs_t o, e;
    for (int k = 0; k < n; k++) cycle(0, 0, '0, '0, '0, '0, '0, '0, 0, 0, o, e);
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    obs_t o, e;
    req0_valid = 1; req0_addr = 13'h0; req0_we = 4'h0; req0_wrdata = '0;
    req1_valid = 1; req1_addr = 13'h4; req1_we = 4'h0; req1_wrdata = '0;
`ifdef BRAM_ARB_LOCK_EN
    req0_lock = 0; req1_lock = 0;
`endif
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++;
        $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready); end
      @(posedge clk); #1;
      n_checks++; if (bram_we !== 4'h0) begin n_fail++;
        $display("FAIL reset_we got %h exp 0", bram_we); end
      n_checks++; if (req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0) begin n_fail++;
        $display("FAIL reset_rvalid got %b%b exp 00", req0_rvalid, req1_rvalid); end
      n_checks++; if (bram_addr !== 13'h0) begin n_fail++;
        $display("FAIL reset_addr got %h exp 0", bram_addr); end
    end
    reset = 1'b0;
    model_reset();
    cycle(1, 1, 13'h0, 13'h4, '0, '0, '0, '0, 0, 0, o, e);
    n_checks++; if (o.r0 !== 1'b1 || o.r1 !== 1'b0) begin n_fail++;
      $display("FAIL reset_first_grant got %b%b exp 10", o.r0, o.r1); end
    idle(3);
  endtask

  task automatic test_single_read();
    obs_t o, e;
    cycle(1, 0, 13'h1FFC, '0, '0, '0, '0, '0, 0, 0, o, e);
    n_checks++; if (o.r0 !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b exp 1", o.r0); end
    n_checks++; if (o.addr !== 13'h1FFC) begin n_fail++; $display("FAIL single_addr got %h exp 1ffc", o.addr); end
    n_checks++; if (o.rv0 !== 1'b0) begin n_fail++; $display("FAIL single_early_rvalid got %b exp 0", o.rv0); end
    cycle(0, 0, '0, '0, '0, '0, '0, '0, 0, 0, o, e);
    n_checks++; if (o.rv0 !== 1'b1 || o.rv1 !== 1'b0) begin n_fail++;
      $display("FAIL single_rvalid got %b%b exp 10", o.rv0, o.rv1); end
    n_checks++; if (o.rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL single_data got %h exp ffffffff", o.rd); end
    cycle(0, 0, '0, '0, '0, '0, '0, '0, 0, 0, o, e);
    n_checks++; if (o.rv0 !== 1'b0 || o.rv1 !== 1'b0) begin n_fail++;
      $display("FAIL single_rvalid_once got %b%b exp 00", o.rv0, o.rv1); end
  endtask

  task automatic test_conflict();
    obs_t o, e;
    int i0 = 0, i1 = 0;
    logic [31:0] got[$];
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cycle(i0 < 3, i1 < 3, 13'(i0 * 4), 13'(13'h100 + i1 * 4), '0, 32'hA5A5_A5A5, 4'h0, 4'hF, 0, 0, o, e);
      if (k < 6) begin
        n_checks++; if (o.r0 !== 1'((k % 2) == 0) || o.r1 !== 1'((k % 2) == 1)) begin n_fail++;
          $display("FAIL conflict_grant step %0d got %b%b exp %b%b", k, o.r0, o.r1, 1'((k % 2) == 0), 1'((k % 2) == 1)); end
        n_checks++; if (o.we !== (((k % 2) == 1) ? 4'hF : 4'h0)) begin n_fail++;
          $display("FAIL conflict_we step %0d got %h", k, o.we); end
      end
      if (o.r0) i0++; else if (o.r1) i1++;
      if (o.rv0) got.push_back(o.rd);
    end
    n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL conflict_rvalid_count got %0d exp 3", got.size()); end
    for (int j = 0; j < 3 && j < got.size(); j++) begin
      n_checks++; if (got[j] !== init_val(j)) begin n_fail++;
        $display("FAIL conflict_data %0d got %h exp %h", j, got[j], init_val(j)); end
    end
  endtask

  task automatic test_raw();
    obs_t o, e;
    cycle(0, 1, '0, 13'h40, '0, 32'h1234_5678, '0, 4'hF, 0, 0, o, e);
    n_checks++; if (o.r1 !== 1'b1 || o.we !== 4'hF) begin n_fail++;
      $display("FAIL raw_write got ready %b we %h", o.r1, o.we); end
    cycle(1, 0, 13'h40, '0, '0, '0, 4'h0, '0, 0, 0, o, e);
    n_checks++; if (o.r0 !== 1'b1) begin n_fail++; $display("FAIL raw_read_ready got %b exp 1", o.r0); end
    cycle(0, 0, '0, '0, '0, '0, '0, '0, 0, 0, o, e);
    n_checks++; if (o.rv0 !== 1'b1 || o.rd !== 32'h1234_5678) begin n_fail++;
      $display("FAIL raw_data got rvalid %b data %h exp 1 12345678", o.rv0, o.rd); end
    idle(2);
  endtask

`ifdef BRAM_ARB_LOCK_EN
  task automatic test_lock();
    obs_t o, e;
    do_reset();
    cycle(1, 1, 13'h0, 13'h200, '0, 32'h55, 4'h0, 4'hF, 1, 0, o, e);
    n_checks++; if (o.r0 !== 1'b1 || o.r1 !== 1'b0) begin n_fail++;
      $display("FAIL lock_first got %b%b exp 10", o.r0, o.r1); end
    cycle(1, 1, 13'h0, 13'h200, 32'hDEAD_BEEF, 32'h55, 4'hF, 4'hF, 0, 0, o, e);
    n_checks++; if (o.r0 !== 1'b1 || o.r1 !== 1'b0) begin n_fail++;
      $display("FAIL lock_hold got %b%b exp 10", o.r0, o.r1); end
    n_checks++; if (o.rv0 !== 1'b1 || o.rd !== init_val(0)) begin n_fail++;
      $display("FAIL lock_read got %b %h exp 1 %h", o.rv0, o.rd, init_val(0)); end
    cycle(0, 1, '0, 13'h200, '0, 32'h55, '0, 4'hF, 0, 0, o, e);
    n_checks++; if (o.r1 !== 1'b1) begin n_fail++; $display("FAIL lock_release got %b exp 1", o.r1); end
    idle(3);
  endtask
`endif

  task automatic test_reset_mid_read();
    obs_t o, e;
    cycle(0, 1, '0, 13'h300, '0, '0, '0, 4'h0, 0, 0, o, e);
    n_checks++; if (o.r1 !== 1'b1) begin n_fail++; $display("FAIL midrst_accept got %b exp 1", o.r1); end
    req0_valid = 0; req1_valid = 0;
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_checks++; if (req1_rvalid !== 1'b0 || req0_rvalid !== 1'b0 || bram_we !== 4'h0) begin n_fail++;
        $display("FAIL midrst_quiet got rv %b%b we %h", req0_rvalid, req1_rvalid, bram_we); end
    end
    reset = 1'b0;
    cycle(1, 1, 13'h8, 13'hC, '0, '0, '0, '0, 0, 0, o, e);
    n_checks++; if (o.r0 !== 1'b1 || o.r1 !== 1'b0) begin n_fail++;
      $display("FAIL midrst_grant got %b%b exp 10", o.r0, o.r1); end
    idle(3);
  endtask

  task automatic test_random();
    obs_t o, e;
    logic p0, p1, l0, l1;
    logic [12:0] a0, a1;
    logic [31:0] d0, d1;
    logic [3:0]  w0, w1;
    p0 = 0; p1 = 0; l0 = 0; l1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; w0 = '0; w1 = '0;
    do_reset();
    for (int k = 0; k < 500; k++) begin
      if (p0 && ($urandom % 20 == 0)) p0 = 0;
      if (p1 && ($urandom % 20 == 0)) p1 = 0;
      if (!p0 && ($urandom % 10 < 7)) begin
        p0 = 1; a0 = 13'($urandom_range(0, 31) * 4 + $urandom % 4); d0 = $urandom;
        w0 = ($urandom % 2) ? 4'h0 : 4'($urandom_range(1, 15));
`ifdef BRAM_ARB_LOCK_EN
        l0 = ($urandom % 4 == 0);
`endif
      end
      if (!p1 && ($urandom % 10 < 7)) begin
        p1 = 1; a1 = 13'($urandom_range(0, 31) * 4 + $urandom % 4); d1 = $urandom;
        w1 = ($urandom % 2) ? 4'h0 : 4'($urandom_range(1, 15));
`ifdef BRAM_ARB_LOCK_EN
        l1 = ($urandom % 4 == 0);
`endif
      end
      cycle(p0, p1, a0, a1, d0, d1, w0, w1, l0, l1, o, e);
      n_checks++; if (o.r0 !== e.r0 || o.r1 !== e.r1) begin n_fail++;
        $display("FAIL rand_ready cyc %0d got %b%b exp %b%b", k, o.r0, o.r1, e.r0, e.r1); end
      n_checks++; if (o.we !== e.we || o.addr !== e.addr) begin n_fail++;
        $display("FAIL rand_port cyc %0d got we %h addr %h exp we %h addr %h", k, o.we, o.addr, e.we, e.addr); end
      n_checks++; if (o.rv0 !== e.rv0 || o.rv1 !== e.rv1) begin n_fail++;
        $display("FAIL rand_rvalid cyc %0d got %b%b exp %b%b", k, o.rv0, o.rv1, e.rv0, e.rv1); end
      if (e.rv0 || e.rv1) begin
        n_checks++; if (o.rd !== e.rd) begin n_fail++;
          $display("FAIL rand_data cyc %0d got %h exp %h", k, o.rd, e.rd); end
      end
      if (e.r0) p0 = 0;
      if (e.r1) p1 = 0;
    end
    idle(4);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_addr = '0; req0_wrdata = '0; req0_we = '0;
    req1_valid = 0; req1_addr = '0; req1_wrdata = '0; req1_we = '0;
`ifdef BRAM_ARB_LOCK_EN
    req0_lock = 0; req1_lock = 0;
`endif
    model_reset();
    test_reset();
    test_single_read();
    test_conflict();
    test_raw();
`ifdef BRAM_ARB_LOCK_EN
    test_lock();
`endif
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
